// File: rtl/dsc_seq_mul.sv
// Deterministic stochastic-computing multiplier: nested unary streams ANDed and counted.
// Optional early termination on the last operand is enabled by defining DSC_MUL_EARLY_TERM_EN.
module dsc_seq_mul #(
    parameter  int DATA_WIDTH = 5,
    parameter  int NUM_INPUTS = 2,
    localparam int OUT_WIDTH  = DATA_WIDTH * NUM_INPUTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS-1:0],
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [OUT_WIDTH-1:0]  bin_data_out,
    output logic                  bs_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q [NUM_INPUTS-1:0];
    logic [OUT_WIDTH-1:0]  ctr_q;
    logic [OUT_WIDTH-1:0]  acc_q;
    logic                  done_q;
    logic [NUM_INPUTS-1:0] s;
    logic                  bs;
    logic                  accept;
    logic                  last;
    logic                  skip;
    logic                  done_d;

    // One wide counter split into W-bit fields: its carry chain nests the per-operand periods.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            s[i] = (ctr_q[i*DATA_WIDTH +: DATA_WIDTH] < x_q[i]);
        end
    end

    assign bs     = &s;
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DSC_MUL_EARLY_TERM_EN
    localparam int LOW_WIDTH = DATA_WIDTH * (NUM_INPUTS - 1);
    logic [DATA_WIDTH-1:0] top_last;

    // Once the top field reaches x[N-1] its stream is 0 for the rest of the period.
    assign top_last = x_q[NUM_INPUTS-1] - DATA_WIDTH'(1);
    assign last     = (&ctr_q[LOW_WIDTH-1:0]) &&
                      (ctr_q[OUT_WIDTH-1 -: DATA_WIDTH] == top_last);
    assign skip     = (bin_data_in[NUM_INPUTS-1] == '0);
`else
    assign last = &ctr_q;
    assign skip = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = skip ? DONE : RUN;
                    done_d  = skip;
                end
            end
            RUN: begin
                if (en && last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ctr_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                x_q   <= bin_data_in;
                ctr_q <= '0;
                acc_q <= '0;
            end else if ((state_q == RUN) && en) begin
                ctr_q <= ctr_q + OUT_WIDTH'(1);
                acc_q <= acc_q + OUT_WIDTH'(bs);
            end
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = done_q;
    assign result_valid = (state_q == DONE);
    assign bin_data_out = acc_q;
    assign bs_out       = (state_q == RUN) && bs;

endmodule

// File: tb/tb_dsc_seq_mul.sv
// Self-checking bench for dsc_seq_mul (default build): vector table, scoreboard, corner sequences.
module tb_dsc_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, en1;
    logic [2:0] din1 [1:0];
    logic       busy1, done1, rv1, bs1;
    logic [5:0] out1;

    logic       start2, en2;
    logic [1:0] din2 [2:0];
    logic       busy2, done2, rv2, bs2;
    logic [5:0] out2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    typedef struct {
        logic [2:0] a0;
        logic [2:0] a1;
        int         res;
        int         cyc;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [7];

    dsc_seq_mul #(.DATA_WIDTH(3), .NUM_INPUTS(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .en(en1), .bin_data_in(din1),
        .busy(busy1), .done(done1), .result_valid(rv1), .bin_data_out(out1), .bs_out(bs1)
    );

    dsc_seq_mul #(.DATA_WIDTH(2), .NUM_INPUTS(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .en(en2), .bin_data_in(din2),
        .busy(busy2), .done(done2), .result_valid(rv2), .bin_data_out(out2), .bs_out(bs2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation on dut1; a start carrying 7,7 is pulsed at cycle 'poke' (0 = never).
    task automatic run1(input string name, input logic [2:0] a0, input logic [2:0] a1,
                        input int res, input int cyc, input int poke);
        exp_t       e;
        int         n     = 1;
        int         nbusy = 0;
        int         nbs   = 0;
        logic [5:0] held;
        @(negedge clk);
        din1[0] = a0;
        din1[1] = a1;
        start1  = 1'b1;
        sb.push_back('{res, cyc});
        @(negedge clk);
        start1 = 1'b0;
        check({name, " rv cleared"}, {31'd0, rv1}, 32'd0);
        check({name, " acc cleared"}, {26'd0, out1}, 32'd0);
        while (!done1 && n < 300) begin
            if (busy1) nbusy++;
            if (bs1) nbs++;
            if (n == poke) begin
                din1[0] = 3'd7;
                din1[1] = 3'd7;
                start1  = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({name, " done cycle"}, n, e.cyc);
        check({name, " result"}, {26'd0, out1}, e.res);
        check({name, " busy cycles"}, nbusy, e.cyc - 1);
        check({name, " stream ones"}, nbs, e.res);
        check({name, " rv at done"}, {31'd0, rv1}, 32'd1);
        held = out1;
        @(negedge clk);
        check({name, " done pulse width"}, {31'd0, done1}, 32'd0);
        check({name, " rv held"}, {31'd0, rv1}, 32'd1);
        check({name, " result held"}, {26'd0, out1}, {26'd0, held});
        check({name, " bs idle"}, {31'd0, bs1}, 32'd0);
        check({name, " not busy"}, {31'd0, busy1}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"}, {31'd0, busy1}, 32'd0);
        check({name, " done"}, {31'd0, done1}, 32'd0);
        check({name, " rv"}, {31'd0, rv1}, 32'd0);
        check({name, " out"}, {26'd0, out1}, 32'd0);
        check({name, " bs"}, {31'd0, bs1}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd5, 3'd3, 15, 65};
        vecs[1] = '{3'd3, 3'd5, 15, 65};
        vecs[2] = '{3'd7, 3'd7, 49, 65};
        vecs[3] = '{3'd0, 3'd5, 0, 65};
        vecs[4] = '{3'd3, 3'd0, 0, 65};
        vecs[5] = '{3'd1, 3'd1, 1, 65};
        vecs[6] = '{3'd6, 3'd4, 24, 65};

        rst     = 1'b0;
        start1  = 1'b0;
        en1     = 1'b1;
        din1[0] = '0;
        din1[1] = '0;
        start2  = 1'b0;
        en2     = 1'b1;
        for (int i = 0; i < 3; i++) din2[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run1($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].res, vecs[i].cyc, 0);
        end

        // Start pulsed mid-RUN must be ignored.
        run1("midstart", 3'd5, 3'd3, 15, 65, 10);

        // Synchronous reset at cycle 10 of a run aborts it.
        @(negedge clk);
        din1[0] = 3'd5;
        din1[1] = 3'd3;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy before reset", {31'd0, busy1}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("abort");
        run1("after abort", 3'd2, 3'd6, 12, 65, 0);

        // Three 2-bit operands with en toggling: 64 enabled cycles spread over 127.
        begin
            int n   = 1;
            int nbs = 0;
            @(negedge clk);
            din2[0] = 2'd3;
            din2[1] = 2'd2;
            din2[2] = 2'd1;
            start2  = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            while (!done2 && n < 400) begin
                en2 = n[0];
                if (bs2 && en2) nbs++;
                @(negedge clk);
                n++;
            end
            check("en toggle done cycle", n, 128);
            check("en toggle result", {26'd0, out2}, 32'd6);
            check("en toggle stream ones", nbs, 6);
            check("en toggle rv", {31'd0, rv2}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
